bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
- Multi-digit packed-BCD subtractor producing a sign-magnitude result: sign plus |a - b| in BCD.
- Processes one BCD digit per clock, least-significant digit first, under a start/busy/done handshake.
- Parametrised successor to the team's single-digit combinational BCD subtractor; used wherever N-digit decimal differences are needed without N parallel digit stages.
- Adds a negative-result correction pass and input digit validation.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (minimum 1).
- CNT_W, 3, digit-counter width; must satisfy 2**CNT_W >= DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  4*DIGITS  minuend, packed BCD; digit 0 = bits [3:0].
- y  input  4*DIGITS  subtrahend, packed BCD.
- busy  output  1  high in SUB and FIX states.
- done  output  1  one-cycle completion pulse (DONE state).
- sign  output  1  1 = result negative (x < y).
- ans  output  4*DIGITS  magnitude |x - y|, packed BCD.
- invalid  output  1  1 = some captured digit of x or y exceeded 9.

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE, busy=0, done=0, sign=0, invalid=0, ans=0, digit counter=0, borrow=0, operand registers=0.
- FSM states: IDLE, SUB, FIX, DONE.
- Edge numbering: the edge that samples start=1 in IDLE is edge 0.
- IDLE:
  - On start=1, capture x and y into internal registers; later input changes are ignored.
  - If any captured digit > 9: set invalid=1, sign=0, ans=0, go to DONE.
  - Otherwise clear invalid, borrow and counter, and go to SUB.
- SUB, one digit per edge (edges 1..DIGITS):
  - t = x_i - y_i - borrow.
  - If t < 0: digit = t + 10, borrow = 1. Else: digit = t, borrow = 0.
  - The digit is written into ans position i; the counter increments.
  - On the edge that processes digit DIGITS-1: if the final borrow is 1, go to FIX with sign=1; else go to DONE with sign=0.
- FIX, negative result only (edges DIGITS+1..2*DIGITS):
  - Replaces ans with its ten's complement, 0 - ans - borrow, digit by digit with the same rule.
  - Borrow is cleared and the counter reset on FIX entry.
  - After the last digit, go to DONE.
  - The final borrow out of FIX is discarded; it is always 1 when ans is nonzero.
- DONE:
  - done=1 for exactly one cycle, then IDLE on the next edge.
- Latency from edge 0 to the edge that raises done:
  - x >= y: DIGITS.
  - x < y: 2*DIGITS.
  - invalid: 0, so done is high in the cycle immediately after edge 0.
- Holding rules:
  - sign, ans and invalid hold their final values from DONE until the next accepted start.
  - ans shows intermediate digits while busy=1 and must not be sampled then.
- start is ignored in SUB, FIX and DONE; there is no queuing.
- Zero result (x == y): sign=0, ans=0, no FIX pass; "negative zero" is never produced.
- Arithmetic:
  - Digit operations are 5-bit signed internally.
  - All ans digits are legal BCD (0-9) after DONE.
  - DIGITS=1 must work, giving latencies 1 or 2.

Test Plan (DIGITS=4):
1. x=0004, y=0007, start pulse -> busy for 8 cycles, done pulse after edge 8, sign=1, ans=0003, invalid=0.
2. x=0003, y=0008 issued directly after test 1 completes -> sign=1, ans=0005; confirms outputs from the previous result hold until the new start.
3. x=1000, y=0001 (borrow ripples through three digits) -> done after edge 4, sign=0, ans=0999. Then x=0000, y=9999 -> sign=1, ans=9999 after edge 8.
4. x=5678, y=5678 -> sign=0, ans=0000, done after edge 4, no FIX cycles.
5. x=00A3, y=0001 -> done high in the cycle after edge 0, invalid=1, sign=0, ans=0000. Next valid op (x=0002, y=0001) -> invalid=0, ans=0001.
6. Robustness:
   - Start x=0100, y=0200, assert rst on edge 5 (inside FIX) -> all outputs 0 immediately, state IDLE, then a fresh op completes correctly.
   - start held high throughout an op -> exactly one op runs, with a new one accepted only after DONE returns to IDLE.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: one digit per clock, LSD first, sign-magnitude result.
// A negative raw difference is turned into its magnitude by a second ten's-complement pass.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   ans,
    output logic                  invalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] x_q, x_d;
    logic [4*DIGITS-1:0] y_q, y_d;
    logic [4*DIGITS-1:0] ans_q, ans_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                borrow_q, borrow_d;
    logic                sign_q, sign_d;
    logic                invalid_q, invalid_d;

    logic [CNT_W+1:0]    base;
    logic [3:0]          dig_a;
    logic [3:0]          dig_b;
    logic [4:0]          dig_res;
    logic                last_digit;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Returns {borrow_out, digit}; 5-bit signed so a - b - bin down to -10 is representable.
    function automatic logic [4:0] digit_sub(input logic [3:0] a, input logic [3:0] b,
                                             input logic bin);
        logic signed [4:0] t;
        t = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
        if (t < 0) begin
            t = t + 5'sd10;
            return {1'b1, t[3:0]};
        end
        return {1'b0, t[3:0]};
    endfunction

    assign base       = {cnt_q, 2'b00};
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));
    // FIX computes 0 - ans - borrow, reusing the same digit subtractor.
    assign dig_a      = (state_q == FIX) ? 4'd0 : x_q[base +: 4];
    assign dig_b      = (state_q == FIX) ? ans_q[base +: 4] : y_q[base +: 4];
    assign dig_res    = digit_sub(dig_a, dig_b, borrow_q);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ans_d     = ans_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        sign_d    = sign_q;
        invalid_d = invalid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d = x;
                    y_d = y;
                    if (has_bad_digit(x) || has_bad_digit(y)) begin
                        invalid_d = 1'b1;
                        sign_d    = 1'b0;
                        ans_d     = '0;
                        state_d   = DONE;
                    end else begin
                        invalid_d = 1'b0;
                        sign_d    = 1'b0;
                        borrow_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = SUB;
                    end
                end
            end
            SUB: begin
                ans_d[base +: 4] = dig_res[3:0];
                borrow_d         = dig_res[4];
                cnt_d            = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    if (dig_res[4]) begin
                        sign_d   = 1'b1;
                        borrow_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = FIX;
                    end else begin
                        sign_d   = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            FIX: begin
                ans_d[base +: 4] = dig_res[3:0];
                borrow_d         = dig_res[4];
                cnt_d            = cnt_q + CNT_W'(1);
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            ans_q     <= '0;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            sign_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ans_q     <= ans_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            sign_q    <= sign_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy    = (state_q == SUB) || (state_q == FIX);
    assign done    = (state_q == DONE);
    assign sign    = sign_q;
    assign ans     = ans_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor (DIGITS=4): directed vectors, monitor checks on done.
module tb_bcd_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic        sign;
    logic [15:0] ans;
    logic        invalid;

    typedef struct {
        logic        sign;
        logic [15:0] ans;
        logic        inv;
        int          cyc;
        int          busy;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   ops_seen = 0;

    bcd_serial_subtractor #(.DIGITS(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .sign(sign), .ans(ans), .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sign", 32'(sign), 32'(e.sign));
                    chk("ans", 32'(ans), 32'(e.ans));
                    chk("invalid", 32'(invalid), 32'(e.inv));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                end
                busy_cnt = 0;
                ops_seen++;
            end
        end
    end

    task automatic push_exp(input int e0, input logic s, input logic [15:0] a,
                            input logic inv, input int lat);
        exp_t e;
        e.sign = s;
        e.ans  = a;
        e.inv  = inv;
        e.cyc  = e0 + lat + 1;
        e.busy = lat;
        q.push_back(e);
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (ops_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input logic s,
                          input logic [15:0] a, input logic inv, input int lat);
        int e0;
        int target;
        target = ops_seen + 1;
        @(negedge clk);
        x     = xv;
        y     = yv;
        start = 1'b1;
        @(posedge clk);
        e0 = cyc;
        push_exp(e0, s, a, inv, lat);
        #1 start = 1'b0;
        wait_done(target);
    endtask

    initial begin
        int e0;
        int target;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sign", 32'(sign), 32'd0);
        chk("rst_ans", 32'(ans), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;

        run_op(16'h0004, 16'h0007, 1'b1, 16'h0003, 1'b0, 8);
        repeat (3) @(negedge clk);
        chk("hold_sign", 32'(sign), 32'd1);
        chk("hold_ans", 32'(ans), 32'h0003);
        // Inputs change while idle without start: result must not move.
        x = 16'h9999;
        y = 16'h0001;
        @(negedge clk);
        chk("hold_ans_inputs", 32'(ans), 32'h0003);
        run_op(16'h0003, 16'h0008, 1'b1, 16'h0005, 1'b0, 8);

        run_op(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 4);
        run_op(16'h0000, 16'h9999, 1'b1, 16'h9999, 1'b0, 8);
        run_op(16'h5678, 16'h5678, 1'b0, 16'h0000, 1'b0, 4);
        run_op(16'h0321, 16'h1234, 1'b1, 16'h0913, 1'b0, 8);
        run_op(16'h9876, 16'h1234, 1'b0, 16'h8642, 1'b0, 4);

        run_op(16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("hold_invalid", 32'(invalid), 32'd1);
        run_op(16'h0002, 16'h0001, 1'b0, 16'h0001, 1'b0, 4);
        run_op(16'h0001, 16'h0F00, 1'b0, 16'h0000, 1'b1, 0);

        // Reset asserted right after edge 5 (inside FIX).
        @(negedge clk);
        x     = 16'h0100;
        y     = 16'h0200;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_sign", 32'(sign), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sign", 32'(sign), 32'd0);
        chk("midrst_ans", 32'(ans), 32'd0);
        chk("midrst_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0100, 16'h0200, 1'b1, 16'h0100, 1'b0, 8);

        // start held high: one op, then the next accepted only after DONE -> IDLE.
        target = ops_seen + 1;
        @(negedge clk);
        x     = 16'h0002;
        y     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        e0 = cyc;
        push_exp(e0, 1'b0, 16'h0001, 1'b0, 4);
        push_exp(e0 + 4 + 2, 1'b0, 16'h0001, 1'b0, 4);
        wait_done(target);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(target + 1);
        repeat (12) @(negedge clk);
        chk("no_extra_op", 32'(ops_seen), 32'(target + 1));
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
